// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int PORT_INSTR = 0;
    localparam int PORT_DATA  = 1;

    localparam int DEF_AW    = 33;
    localparam int DEF_DW    = 33;
    localparam int DEF_DEPTH = 1024;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: single requester always wins, contention goes to ptr_q.
// Latency: grant is combinational from req in the same cycle.
// Backpressure: no grants while advance is low; pointer flips only on contended grants.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       ptr_q
);

    logic ptr_d;

    // Pick the winner and decide whether the pointer moves this cycle.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (advance) begin
            if (req == 2'b11) begin
                gnt   = ptr_q ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end else begin
                gnt = req;
            end
        end
    end

    // Pointer register; after reset the instruction port has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'(PORT_INSTR);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Zero-fills a 1-cycle block RAM after reset, then round-robins its single port between two requesters.
// Latency: grant is combinational (0 cycles uncontended); response strobe exactly 1 cycle after grant.
// Backpressure: requests are held by the requester until granted; INIT grants nothing, contention loser waits 1 cycle.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int INIT_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_dout,
    output logic          init_done
);

    localparam int CW = $clog2(DEPTH);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_vld_q, rsp_vld_d;
    logic          rsp_owner_q, rsp_owner_d;
    logic          rsp_wr_q, rsp_wr_d;
    logic          run_en;
    logic [1:0]    arb_gnt;
    // Pointer is only of interest when probing the arbiter; the grant vector carries the decision.
    logic          arb_ptr_unused;

    // Arbitration is frozen during INIT and while reset is asserted.
    assign run_en = (state_q == ST_RUN) && !rst;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({p1_req, p0_req}),
        .advance (run_en),
        .gnt     (arb_gnt),
        .ptr_q   (arb_ptr_unused)
    );

    assign p0_gnt    = arb_gnt[PORT_INSTR];
    assign p1_gnt    = arb_gnt[PORT_DATA];
    assign init_done = (state_q == ST_RUN) && !rst;

    // State, init counter and response-tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            cnt_q       <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_wr_q    <= rsp_wr_d;
        end
    end

    // Walk the counter through every word once, then hand the RAM over to the requesters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Drive the RAM port: zero-fill writes in INIT, the granted requester in RUN, idle otherwise.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = AW'(cnt_q) << 2;
            end else if (arb_gnt[PORT_DATA]) begin
                ram_en   = 1'b1;
                ram_we   = p1_we;
                ram_addr = p1_addr;
                ram_di   = p1_wdata;
            end else if (arb_gnt[PORT_INSTR]) begin
                ram_en   = 1'b1;
                ram_we   = p0_we;
                ram_addr = p0_addr;
                ram_di   = p0_wdata;
            end
        end
    end

    // Remember who was granted and whether it was a write, so next cycle's RAM output is routed correctly.
    always_comb begin
        rsp_vld_d   = |arb_gnt;
        rsp_owner_d = arb_gnt[PORT_DATA];
        rsp_wr_d    = arb_gnt[PORT_DATA] ? p1_we : p0_we;
    end

    // Reset masks the strobe immediately so a pending response is dropped in the reset cycle.
    assign p0_rvalid = rsp_vld_q && (rsp_owner_q == 1'(PORT_INSTR)) && !rst;
    assign p1_rvalid = rsp_vld_q && (rsp_owner_q == 1'(PORT_DATA)) && !rst;
    assign p0_rdata  = (p0_rvalid && !rsp_wr_q) ? ram_dout : '0;
    assign p1_rdata  = (p1_rvalid && !rsp_wr_q) ? ram_dout : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with a behavioural no-change RAM and a transaction-level reference model.
// Latency: n/a.
// Backpressure: requesters hold requests until granted.
module tb_ram_port_arbiter;

    localparam int AW    = 33;
    localparam int DW    = 33;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di, ram_dout;
    logic          init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .INIT_EN(1)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_dout(ram_dout), .init_done(init_done)
    );

    // Behavioural block RAM, no-change mode; never-written words read back as garbage.
    logic [DW-1:0] ram_mem [DEPTH];
    bit            written [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr[11:2]] <= ram_di;
                written[ram_addr[11:2]] <= 1'b1;
            end else begin
                ram_dout <= written[ram_addr[11:2]] ? ram_mem[ram_addr[11:2]] : 33'h1DEADBEEF;
            end
        end
    end

    // Reference model: memory contents as a requester sees them, contention turn, expected response.
    bit [DW-1:0] exp_mem [DEPTH];
    int          turn;
    bit          pend_vld;
    int          pend_owner;
    bit [DW-1:0] pend_data;

    task automatic model_reset();
        turn     = 0;
        pend_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    endtask

    // One RUN cycle: drive requests, check response and grant against the model, advance.
    task automatic run_cycle(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                             input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                             output bit g0, output bit g1);
        int            win;
        bit            e_rv0, e_rv1;
        logic [DW-1:0] e_rd0, e_rd1;
        logic [AW-1:0] wa;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #3;
        e_rv0 = pend_vld && (pend_owner == 0);
        e_rv1 = pend_vld && (pend_owner == 1);
        e_rd0 = e_rv0 ? pend_data : '0;
        e_rd1 = e_rv1 ? pend_data : '0;
        checks += 4;
        if (p0_rvalid !== e_rv0) begin errors++; $display("FAIL p0_rvalid got %b want %b", p0_rvalid, e_rv0); end
        if (p1_rvalid !== e_rv1) begin errors++; $display("FAIL p1_rvalid got %b want %b", p1_rvalid, e_rv1); end
        if (p0_rdata !== e_rd0) begin errors++; $display("FAIL p0_rdata got %h want %h", p0_rdata, e_rd0); end
        if (p1_rdata !== e_rd1) begin errors++; $display("FAIL p1_rdata got %h want %h", p1_rdata, e_rd1); end
        if (r0 && r1) begin win = turn; turn = 1 - turn; end
        else if (r0) win = 0;
        else if (r1) win = 1;
        else win = -1;
        checks += 3;
        if (p0_gnt !== (win == 0)) begin errors++; $display("FAIL p0_gnt got %b want %b", p0_gnt, win == 0); end
        if (p1_gnt !== (win == 1)) begin errors++; $display("FAIL p1_gnt got %b want %b", p1_gnt, win == 1); end
        if (ram_en !== (win >= 0)) begin errors++; $display("FAIL ram_en got %b want %b", ram_en, win >= 0); end
        pend_vld = (win >= 0);
        if (win >= 0) begin
            pend_owner = win;
            wa = (win == 0) ? a0 : a1;
            checks += 3;
            if (ram_we !== ((win == 0) ? w0 : w1)) begin errors++; $display("FAIL ram_we got %b", ram_we); end
            if (ram_addr !== wa) begin errors++; $display("FAIL ram_addr got %h want %h", ram_addr, wa); end
            if (ram_di !== ((win == 0) ? d0 : d1)) begin errors++; $display("FAIL ram_di got %h", ram_di); end
            if ((win == 0) ? w0 : w1) begin
                pend_data = '0;
                exp_mem[wa[11:2]] = (win == 0) ? d0 : d1;
            end else begin
                pend_data = exp_mem[wa[11:2]];
            end
        end
        g0 = p0_gnt;
        g1 = p1_gnt;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 33'h44; p0_wdata = 33'h1FFFFFFFF;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 33'h48; p1_wdata = 33'h0AAAA5555;
        for (int c = 0; c < 2; c++) begin
            #3;
            checks++;
            if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, ram_en, ram_we, ram_addr, ram_di, init_done} !== '0)
                begin errors++; $display("FAIL reset_outputs got gnt=%b%b en=%b addr=%h init_done=%b want all zero",
                                         p0_gnt, p1_gnt, ram_en, ram_addr, init_done); end
            @(posedge clk); #1;
        end
        model_reset();
    endtask

    // n INIT cycles starting at word 0, with p0 holding a read request the whole time.
    task automatic init_cycles(input int n);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = '0; p1_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            #3;
            checks += 5;
            if (ram_en !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL init_ctl cyc %0d en=%b we=%b", i, ram_en, ram_we); end
            if (ram_addr !== AW'(i * 4)) begin errors++; $display("FAIL init_addr cyc %0d got %h want %h", i, ram_addr, i * 4); end
            if (ram_di !== '0) begin errors++; $display("FAIL init_di cyc %0d got %h want 0", i, ram_di); end
            if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin errors++; $display("FAIL init_gnt cyc %0d got %b%b want 00", i, p0_gnt, p1_gnt); end
            if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early cyc %0d got %b want 0", i, init_done); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_init_restart();
        bit g0, g1;
        rst = 1'b0;
        init_cycles(500);
        rst = 1'b1;
        #3;
        checks++;
        if (ram_en !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL mid_init_rst en=%b done=%b want 0 0", ram_en, init_done); end
        @(posedge clk); #1;
        rst = 1'b0;
        init_cycles(DEPTH);
        checks++;
        if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got %b want 1 after %0d cycles", init_done, DEPTH); end
        run_cycle(1, 0, 33'h0, '0, 0, 0, '0, '0, g0, g1);
    endtask

    task automatic test_write_read();
        bit g0, g1;
        run_cycle(0, 0, '0, '0, 1, 1, 33'h40, 33'h123456789, g0, g1);
        run_cycle(1, 0, 33'h40, '0, 0, 0, '0, '0, g0, g1);
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 33'h123456789)
            begin errors++; $display("FAIL wr_rd_data rvalid=%b rdata=%h want 1 123456789", p0_rvalid, p0_rdata); end
        run_cycle(0, 0, '0, '0, 0, 0, '0, '0, g0, g1);
    endtask

    task automatic test_alternate();
        bit g0, g1;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1, 0, AW'($urandom_range(0, 15) * 4), '0, 1, 0, AW'($urandom_range(0, 15) * 4), '0, g0, g1);
            checks++;
            if (g0 !== (i % 2 == 0)) begin errors++; $display("FAIL alt_gnt cyc %0d p0_gnt=%b want %b", i, g0, i % 2 == 0); end
        end
        run_cycle(0, 0, '0, '0, 0, 0, '0, '0, g0, g1);
    endtask

    task automatic test_single_then_both();
        bit g0, g1;
        for (int i = 0; i < 4; i++)
            run_cycle(0, 0, '0, '0, 1, 1'($urandom), AW'($urandom_range(0, 7) * 4), {1'b0, $urandom}, g0, g1);
        run_cycle(1, 0, 33'h4, '0, 1, 0, 33'h8, '0, g0, g1);
        checks++;
        if (g0 !== 1'b1 || g1 !== 1'b0) begin errors++; $display("FAIL first_contend got %b%b want 10", g0, g1); end
        run_cycle(0, 0, '0, '0, 1, 0, 33'h8, '0, g0, g1);
        checks++;
        if (g1 !== 1'b1) begin errors++; $display("FAIL loser_next got %b want 1", g1); end
    endtask

    task automatic test_random();
        bit            q0 = 0, q1 = 0, w0 = 0, w1 = 0, g0, g1;
        logic [AW-1:0] a0 = '0, a1 = '0;
        logic [DW-1:0] d0 = '0, d1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!q0 && $urandom_range(0, 99) < 60) begin
                q0 = 1; w0 = 1'($urandom); a0 = AW'($urandom_range(0, 31)); d0 = {1'($urandom), $urandom};
            end else if (q0 && $urandom_range(0, 99) < 5) q0 = 0;
            if (!q1 && $urandom_range(0, 99) < 60) begin
                q1 = 1; w1 = 1'($urandom); a1 = AW'($urandom_range(0, 31)); d1 = {1'($urandom), $urandom};
            end else if (q1 && $urandom_range(0, 99) < 5) q1 = 0;
            run_cycle(q0, w0, a0, d0, q1, w1, a1, d1, g0, g1);
            if (g0) q0 = 0;
            if (g1) q1 = 0;
        end
        run_cycle(0, 0, '0, '0, 0, 0, '0, '0, g0, g1);
    endtask

    task automatic test_rst_pending();
        bit g0, g1;
        run_cycle(1, 0, 33'h40, '0, 0, 0, '0, '0, g0, g1);
        p0_req = 1'b1; p1_req = 1'b1;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #3;
            checks += 2;
            if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL rst_drop_rvalid got %b want 0", p0_rvalid); end
            if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, ram_en, ram_we, ram_addr, ram_di, init_done} !== '0)
                begin errors++; $display("FAIL rst_run_outputs gnt=%b%b en=%b done=%b want all zero", p0_gnt, p1_gnt, ram_en, init_done); end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        model_reset();
        init_cycles(2);
    endtask

    initial begin
        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        @(posedge clk); #1;
        test_reset();
        test_init_restart();
        test_write_read();
        test_alternate();
        test_single_then_both();
        test_random();
        test_rst_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
